// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache memory arbiter.
//   mem_src_e      : request/return source tag (I$ = 0, D$ = 1)
//   wt_arb_state_e : arbiter FSM state
//   wt_mem_hold_t  : captured memory request payload, sized by the Wt* widths
package wt_cache_pkg;

  localparam int unsigned WtAddrWidth = 64;
  localparam int unsigned WtDataWidth = 64;
  localparam int unsigned WtTidWidth  = 2;
  localparam int unsigned WtBeWidth   = WtDataWidth / 8;
  localparam int unsigned WtCntWidth  = 4;

  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_DCACHE = 1'b1
  } mem_src_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } wt_arb_state_e;

  typedef struct packed {
    mem_src_e               src;
    logic                   we;
    logic [WtAddrWidth-1:0] addr;
    logic [WtDataWidth-1:0] wdata;
    logic [WtBeWidth-1:0]   be;
    logic [WtTidWidth-1:0]  tid;
  } wt_mem_hold_t;

endpackage

// File: rtl/wt_tx_credit_cnt.sv
// Outstanding-transaction credit counter for one requester.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   inc_i        : a request of this source was granted
//   dec_i        : a return for this source arrived
//   full_o       : MaxTx transactions outstanding, no new request may issue
//   empty_o      : nothing outstanding
//   underflow_o  : return arrived while nothing was outstanding
module wt_tx_credit_cnt
  import wt_cache_pkg::*;
#(
  parameter int unsigned MaxTx = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o,
  output logic underflow_o
);

  localparam logic [WtCntWidth-1:0] MaxCnt = WtCntWidth'(MaxTx);

  logic [WtCntWidth-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec leave the count unchanged; a lone dec at zero holds at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full_o      = (cnt_q >= MaxCnt);
  assign empty_o     = (cnt_q == '0);
  assign underflow_o = dec_i & empty_o;

endmodule

// File: rtl/wt_mem_arbiter.sv
// Arbitrates the single memory request channel between I$ misses and D$ misses/writes.
//   stall_i                 : blocks capture of new requests (a held request still completes)
//   icache_* / dcache_*     : requester interfaces; ack_o is combinational in the capture cycle
//   mem_*                   : registered request to memory, held until mem_gnt_i
//   mem_rtrn_vld_i/src_i    : memory return, steered to icache/dcache_rtrn_vld_o
//   busy_o                  : a request is held or any transaction is outstanding
//   err_o                   : sticky, a return arrived for a source with nothing outstanding
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned AddrWidth   = WtAddrWidth,
  parameter int unsigned DataWidth   = WtDataWidth,
  parameter int unsigned TidWidth    = WtTidWidth,
  parameter int unsigned IcacheMaxTx = 1,
  parameter int unsigned DcacheMaxTx = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic                   icache_req_i,
  output logic                   icache_ack_o,
  input  logic [AddrWidth-1:0]   icache_addr_i,
  input  logic [TidWidth-1:0]    icache_tid_i,
  input  logic                   dcache_req_i,
  output logic                   dcache_ack_o,
  input  logic                   dcache_we_i,
  input  logic [AddrWidth-1:0]   dcache_addr_i,
  input  logic [DataWidth-1:0]   dcache_wdata_i,
  input  logic [DataWidth/8-1:0] dcache_be_i,
  input  logic [TidWidth-1:0]    dcache_tid_i,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic                   mem_src_o,
  output logic                   mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [TidWidth-1:0]    mem_tid_o,
  input  logic                   mem_rtrn_vld_i,
  input  logic                   mem_rtrn_src_i,
  output logic                   icache_rtrn_vld_o,
  output logic                   dcache_rtrn_vld_o,
  output logic                   busy_o,
  output logic                   err_o
);

  wt_arb_state_e state_q;
  mem_src_e      rr_q;      // source served last; the other one wins a tie
  wt_mem_hold_t  hold_q, cap;
  logic          err_q;

  logic i_full, i_empty, i_uf, i_inc, i_dec;
  logic d_full, d_empty, d_uf, d_inc, d_dec;
  logic i_elig, d_elig, pick_i, pick_d, grant;

  assign i_elig = icache_req_i & ~i_full & ~stall_i;
  assign d_elig = dcache_req_i & ~d_full & ~stall_i;

  assign pick_d = (state_q == IDLE) & d_elig & (~i_elig | (rr_q == SRC_ICACHE));
  assign pick_i = (state_q == IDLE) & i_elig & ~pick_d;

  assign icache_ack_o = pick_i;
  assign dcache_ack_o = pick_d;

  always_comb begin
    if (pick_d) begin
      cap.src   = SRC_DCACHE;
      cap.we    = dcache_we_i;
      cap.addr  = dcache_addr_i;
      cap.wdata = dcache_wdata_i;
      cap.be    = dcache_be_i;
      cap.tid   = dcache_tid_i;
    end else begin
      cap.src   = SRC_ICACHE;
      cap.we    = 1'b0;
      cap.addr  = icache_addr_i;
      cap.wdata = '0;
      cap.be    = '1;
      cap.tid   = icache_tid_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= SRC_ICACHE;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_i || pick_d) begin
            hold_q  <= cap;
            rr_q    <= pick_d ? SRC_DCACHE : SRC_ICACHE;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (mem_gnt_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = (state_q == HOLD) & mem_gnt_i;
  assign i_inc = grant & (hold_q.src == SRC_ICACHE);
  assign d_inc = grant & (hold_q.src == SRC_DCACHE);
  assign i_dec = mem_rtrn_vld_i & ~mem_rtrn_src_i;
  assign d_dec = mem_rtrn_vld_i & mem_rtrn_src_i;

  wt_tx_credit_cnt #(
    .MaxTx(IcacheMaxTx)
  ) u_icache_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (i_inc),
    .dec_i      (i_dec),
    .full_o     (i_full),
    .empty_o    (i_empty),
    .underflow_o(i_uf)
  );

  wt_tx_credit_cnt #(
    .MaxTx(DcacheMaxTx)
  ) u_dcache_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (d_inc),
    .dec_i      (d_dec),
    .full_o     (d_full),
    .empty_o    (d_empty),
    .underflow_o(d_uf)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (i_uf || d_uf) begin
      err_q <= 1'b1;
    end
  end

  assign mem_req_o   = (state_q == HOLD);
  assign mem_src_o   = hold_q.src;
  assign mem_we_o    = hold_q.we;
  assign mem_addr_o  = hold_q.addr;
  assign mem_wdata_o = hold_q.wdata;
  assign mem_be_o    = hold_q.be;
  assign mem_tid_o   = hold_q.tid;

  assign icache_rtrn_vld_o = i_dec;
  assign dcache_rtrn_vld_o = d_dec;

  assign busy_o = (state_q == HOLD) | ~i_empty | ~d_empty;
  assign err_o  = err_q;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Directed self-checking bench for wt_mem_arbiter: expected memory requests are queued
// when a request is driven and accepted, and compared when the memory side sees them.
module tb_wt_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        icache_req_i, icache_ack_o;
  logic [63:0] icache_addr_i;
  logic [1:0]  icache_tid_i;
  logic        dcache_req_i, dcache_ack_o, dcache_we_i;
  logic [63:0] dcache_addr_i, dcache_wdata_i;
  logic [7:0]  dcache_be_i;
  logic [1:0]  dcache_tid_i;
  logic        mem_req_o, mem_gnt_i, mem_src_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic [1:0]  mem_tid_o;
  logic        mem_rtrn_vld_i, mem_rtrn_src_i;
  logic        icache_rtrn_vld_o, dcache_rtrn_vld_o, busy_o, err_o;

  typedef struct packed {
    logic        src;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [1:0]  tid;
  } req_t;

  req_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  wt_mem_arbiter #(
    .AddrWidth  (64),
    .DataWidth  (64),
    .TidWidth   (2),
    .IcacheMaxTx(1),
    .DcacheMaxTx(4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .icache_req_i     (icache_req_i),
    .icache_ack_o     (icache_ack_o),
    .icache_addr_i    (icache_addr_i),
    .icache_tid_i     (icache_tid_i),
    .dcache_req_i     (dcache_req_i),
    .dcache_ack_o     (dcache_ack_o),
    .dcache_we_i      (dcache_we_i),
    .dcache_addr_i    (dcache_addr_i),
    .dcache_wdata_i   (dcache_wdata_i),
    .dcache_be_i      (dcache_be_i),
    .dcache_tid_i     (dcache_tid_i),
    .mem_req_o        (mem_req_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_src_o        (mem_src_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_be_o         (mem_be_o),
    .mem_tid_o        (mem_tid_o),
    .mem_rtrn_vld_i   (mem_rtrn_vld_i),
    .mem_rtrn_src_i   (mem_rtrn_src_i),
    .icache_rtrn_vld_o(icache_rtrn_vld_o),
    .dcache_rtrn_vld_o(dcache_rtrn_vld_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t dpay(input int k);
    req_t r;
    r.src   = 1'b1;
    r.we    = 1'b1;
    r.addr  = 64'h3000 + 64'(k * 8);
    r.wdata = {32'hD0D0_0000, 32'(k)};
    r.be    = 8'hF0 ^ 8'(k);
    r.tid   = 2'(k);
    return r;
  endfunction

  task automatic drive_d(input req_t r);
    dcache_we_i    = r.we;
    dcache_addr_i  = r.addr;
    dcache_wdata_i = r.wdata;
    dcache_be_i    = r.be;
    dcache_tid_i   = r.tid;
  endtask

  task automatic pop_chk(input string tag);
    req_t e;
    checks++;
    assert (exp_q.size() != 0)
    else begin
      errors++;
      $error("FAIL %s observed=unexpected_request expected=empty_scoreboard", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ".src"}, 64'(mem_src_o), 64'(e.src));
      chk({tag, ".we"}, 64'(mem_we_o), 64'(e.we));
      chk({tag, ".addr"}, mem_addr_o, e.addr);
      chk({tag, ".wdata"}, mem_wdata_o, e.wdata);
      chk({tag, ".be"}, 64'(mem_be_o), 64'(e.be));
      chk({tag, ".tid"}, 64'(mem_tid_o), 64'(e.tid));
    end
  endtask

  // Called at posedge+1 in IDLE; captures, grants in the HOLD cycle, returns at posedge+1.
  task automatic issue_d(input int k);
    drive_d(dpay(k));
    dcache_req_i = 1'b1;
    @(negedge clk_i);
    chk("issue_d.ack", 64'(dcache_ack_o), 64'd1);
    exp_q.push_back(dpay(k));
    tick();
    dcache_req_i = 1'b0;
    mem_gnt_i    = 1'b1;
    @(negedge clk_i);
    chk("issue_d.req", 64'(mem_req_o), 64'd1);
    pop_chk("issue_d");
    tick();
    mem_gnt_i = 1'b0;
  endtask

  initial begin
    int   acks, grants, idx;
    logic ack_seen, ret_pend, ret_src;
    req_t e;

    rst_i = 1'b1;
    stall_i = 1'b0;
    icache_req_i = 1'b0; icache_addr_i = '0; icache_tid_i = '0;
    dcache_req_i = 1'b0; dcache_we_i = 1'b0; dcache_addr_i = '0;
    dcache_wdata_i = '0; dcache_be_i = '0; dcache_tid_i = '0;
    mem_gnt_i = 1'b0; mem_rtrn_vld_i = 1'b0; mem_rtrn_src_i = 1'b0;

    // Reset state
    #12;
    chk("rst.mem_req", 64'(mem_req_o), 64'd0);
    chk("rst.busy", 64'(busy_o), 64'd0);
    chk("rst.err", 64'(err_o), 64'd0);
    chk("rst.addr", mem_addr_o, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();

    // stall_i blocks capture
    stall_i = 1'b1;
    icache_req_i = 1'b1; icache_addr_i = 64'h8000_0040; icache_tid_i = 2'd0;
    @(negedge clk_i);
    chk("stall.ack", 64'(icache_ack_o), 64'd0);
    tick();
    stall_i = 1'b0;

    // Single I$ request, granted in its first HOLD cycle, then returned
    @(negedge clk_i);
    chk("t1.iack", 64'(icache_ack_o), 64'd1);
    chk("t1.dack", 64'(dcache_ack_o), 64'd0);
    chk("t1.req0", 64'(mem_req_o), 64'd0);
    exp_q.push_back('{src: 1'b0, we: 1'b0, addr: 64'h8000_0040, wdata: 64'd0,
                      be: 8'hFF, tid: 2'd0});
    tick();
    icache_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("t1.req1", 64'(mem_req_o), 64'd1);
    chk("t1.iack_hold", 64'(icache_ack_o), 64'd0);
    pop_chk("t1");
    tick();
    mem_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("t1.busy", 64'(busy_o), 64'd1);
    chk("t1.req_done", 64'(mem_req_o), 64'd0);
    tick();
    mem_rtrn_vld_i = 1'b1; mem_rtrn_src_i = 1'b0;
    @(negedge clk_i);
    chk("t1.irtrn", 64'(icache_rtrn_vld_o), 64'd1);
    chk("t1.drtrn", 64'(dcache_rtrn_vld_o), 64'd0);
    tick();
    mem_rtrn_vld_i = 1'b0;
    @(negedge clk_i);
    chk("t1.busy_clr", 64'(busy_o), 64'd0);
    tick();

    // Both requesting every cycle: last served was I$, so D,I,D,I
    icache_req_i = 1'b1; icache_addr_i = 64'h1000; icache_tid_i = 2'd1;
    e = '{src: 1'b1, we: 1'b1, addr: 64'h2000, wdata: 64'h55, be: 8'h3C, tid: 2'd2};
    drive_d(e);
    dcache_req_i = 1'b1;
    mem_gnt_i = 1'b1;
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back(e);
      exp_q.push_back('{src: 1'b0, we: 1'b0, addr: 64'h1000, wdata: 64'd0,
                        be: 8'hFF, tid: 2'd1});
    end
    grants = 0; ret_pend = 1'b0; ret_src = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      ret_pend = 1'b0;
      if (mem_req_o) begin
        grants++;
        pop_chk("t2");
        ret_pend = 1'b1;
        ret_src  = mem_src_o;
      end
      tick();
      mem_rtrn_vld_i = ret_pend;
      mem_rtrn_src_i = ret_src;
    end
    icache_req_i = 1'b0; dcache_req_i = 1'b0; mem_gnt_i = 1'b0;
    chk("t2.grants", 64'(grants), 64'd4);
    tick();
    mem_rtrn_vld_i = 1'b0;
    @(negedge clk_i);
    chk("t2.busy", 64'(busy_o), 64'd0);
    tick();

    // D$ credit limit: five writes, no returns, only four accepted
    idx = 0; acks = 0;
    drive_d(dpay(0));
    dcache_req_i = 1'b1;
    mem_gnt_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      ack_seen = dcache_ack_o;
      if (ack_seen) begin
        acks++;
        exp_q.push_back(dpay(idx));
      end
      if (mem_req_o) pop_chk("t3");
      tick();
      if (ack_seen) begin
        idx++;
        drive_d(dpay(idx));
      end
    end
    chk("t3.acks", 64'(acks), 64'd4);
    mem_rtrn_vld_i = 1'b1; mem_rtrn_src_i = 1'b1;
    @(negedge clk_i);
    chk("t3.no_ack_full", 64'(dcache_ack_o), 64'd0);
    tick();
    mem_rtrn_vld_i = 1'b0;
    @(negedge clk_i);
    chk("t3.ack5", 64'(dcache_ack_o), 64'd1);
    exp_q.push_back(dpay(4));
    tick();
    dcache_req_i = 1'b0;
    @(negedge clk_i);
    pop_chk("t3.fifth");
    tick();
    mem_gnt_i = 1'b0;
    mem_rtrn_vld_i = 1'b1; mem_rtrn_src_i = 1'b1;
    repeat (4) tick();
    mem_rtrn_vld_i = 1'b0;
    @(negedge clk_i);
    chk("t3.busy", 64'(busy_o), 64'd0);
    chk("t3.err", 64'(err_o), 64'd0);
    tick();

    // Held request keeps its payload while the D$ inputs move
    e = '{src: 1'b1, we: 1'b1, addr: 64'h4440, wdata: 64'hAAAA_5555_AAAA_5555,
          be: 8'hA5, tid: 2'd3};
    drive_d(e);
    dcache_req_i = 1'b1;
    @(negedge clk_i);
    chk("t4.ack", 64'(dcache_ack_o), 64'd1);
    exp_q.push_back(e);
    for (int c = 0; c < 10; c++) begin
      tick();
      dcache_wdata_i = {$urandom, $urandom};
      @(negedge clk_i);
      chk("t4.req", 64'(mem_req_o), 64'd1);
      chk("t4.wdata", mem_wdata_o, e.wdata);
      chk("t4.no_ack", 64'(dcache_ack_o), 64'd0);
    end
    tick();
    dcache_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    pop_chk("t4");
    tick();
    mem_gnt_i = 1'b0;
    mem_rtrn_vld_i = 1'b1; mem_rtrn_src_i = 1'b1;
    tick();
    mem_rtrn_vld_i = 1'b0;

    // Grant and return for D$ in the same cycle with two outstanding
    issue_d(5);
    issue_d(6);
    drive_d(dpay(7));
    dcache_req_i = 1'b1;
    @(negedge clk_i);
    chk("t5.ack", 64'(dcache_ack_o), 64'd1);
    exp_q.push_back(dpay(7));
    tick();
    dcache_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    mem_rtrn_vld_i = 1'b1; mem_rtrn_src_i = 1'b1;
    @(negedge clk_i);
    pop_chk("t5");
    chk("t5.drtrn", 64'(dcache_rtrn_vld_o), 64'd1);
    tick();
    mem_gnt_i = 1'b0;
    mem_rtrn_vld_i = 1'b0;
    @(negedge clk_i);
    chk("t5.busy2", 64'(busy_o), 64'd1);
    tick();
    mem_rtrn_vld_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("t5.busy1", 64'(busy_o), 64'd1);
    tick();
    mem_rtrn_vld_i = 1'b0;
    @(negedge clk_i);
    chk("t5.busy0", 64'(busy_o), 64'd0);
    chk("t5.err0", 64'(err_o), 64'd0);
    tick();
    mem_rtrn_vld_i = 1'b1; mem_rtrn_src_i = 1'b0;
    @(negedge clk_i);
    chk("t5.irtrn", 64'(icache_rtrn_vld_o), 64'd1);
    tick();
    mem_rtrn_vld_i = 1'b0;
    @(negedge clk_i);
    chk("t5.err_set", 64'(err_o), 64'd1);
    tick();
    tick();
    @(negedge clk_i);
    chk("t5.err_sticky", 64'(err_o), 64'd1);
    chk("t5.busy_err", 64'(busy_o), 64'd0);
    tick();

    // Asynchronous reset while holding a request with three D$ outstanding
    issue_d(8);
    issue_d(9);
    issue_d(10);
    drive_d(dpay(11));
    dcache_req_i = 1'b1;
    @(negedge clk_i);
    chk("t6.ack", 64'(dcache_ack_o), 64'd1);
    tick();
    dcache_req_i = 1'b0;
    @(negedge clk_i);
    chk("t6.req_held", 64'(mem_req_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6.req_drop", 64'(mem_req_o), 64'd0);
    chk("t6.busy", 64'(busy_o), 64'd0);
    chk("t6.err", 64'(err_o), 64'd0);
    chk("t6.src", 64'(mem_src_o), 64'd0);
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    // Counter must be back at zero, so a D$ return now is an underflow
    mem_rtrn_vld_i = 1'b1; mem_rtrn_src_i = 1'b1;
    @(negedge clk_i);
    chk("t6.busy_post", 64'(busy_o), 64'd0);
    tick();
    mem_rtrn_vld_i = 1'b0;
    @(negedge clk_i);
    chk("t6.dcnt_zero", 64'(err_o), 64'd1);
    chk("t6.sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
